// File: rtl/spi_frame_scheduler_if.sv
// Byte-write request bus shared by the two application requesters of spi_frame_scheduler.
// The master side holds req/addr/wdata until it sees its combinational grant.
interface spi_frame_scheduler_if;
  logic       req_a;
  logic [7:0] addr_a;
  logic [7:0] wdata_a;
  logic       gnt_a;
  logic       req_b;
  logic [7:0] addr_b;
  logic [7:0] wdata_b;
  logic       gnt_b;

  modport master (
    output req_a, addr_a, wdata_a,
    output req_b, addr_b, wdata_b,
    input  gnt_a, gnt_b
  );

  modport slave (
    input  req_a, addr_a, wdata_a,
    input  req_b, addr_b, wdata_b,
    output gnt_a, gnt_b
  );
endinterface

// File: rtl/spi_frame_scheduler.sv
// Owns the spi_driver transmit frame (round-robin byte writes, locked during exchanges)
// and snapshots each received frame into a byte-readable shadow.
module spi_frame_scheduler (
  input  logic                  sysclock,
  input  logic                  sysreset,
  input  logic                  busy,
  input  logic                  wdog_alarm,
  input  logic [2047:0]         copi_data,
  output logic [2047:0]         cipo_data,
  spi_frame_scheduler_if.slave  wr,
  input  logic [7:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  frame_valid,
  output logic [15:0]           frame_count,
  output logic                  alarm_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_LATCH,
    S_DONE,
    S_ALARM
  } state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  state_e        state_q, state_d;
  port_e         last_q, last_d;
  logic          busy_q;
  logic [2047:0] cipo_q;
  logic [2047:0] rx_shadow_q;
  logic [7:0]    rd_data_q;
  logic [15:0]   frame_count_q;
  logic          gnt_a, gnt_b;
  logic          grant_window;
  logic          latch_en;
  logic          alarm_entry;

  // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
  always_comb begin : next_state
    state_d = state_q;
    if (wdog_alarm) begin
      state_d = S_ALARM;
    end else begin
      case (state_q)
        S_ALARM: state_d = S_IDLE;
        S_IDLE:  if (busy) state_d = S_XFER;
        S_XFER:  if (!busy && busy_q) state_d = S_LATCH;
        S_LATCH: state_d = S_DONE;
        S_DONE:  state_d = busy ? S_XFER : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The alarm term keeps a grant from racing the frame clear on the edge that enters ALARM.
  always_comb begin : arbiter
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    last_d       = last_q;
    grant_window = (state_q == S_IDLE) && !busy && !wdog_alarm && !sysreset;
    if (grant_window) begin
      if (wr.req_a && (!wr.req_b || last_q == PORT_B)) begin
        gnt_a  = 1'b1;
        last_d = PORT_A;
      end else if (wr.req_b) begin
        gnt_b  = 1'b1;
        last_d = PORT_B;
      end
    end
  end

  assign latch_en    = (state_q == S_LATCH) && !wdog_alarm;
  assign alarm_entry = (state_d == S_ALARM) && (state_q != S_ALARM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclock) begin
    if (sysreset) begin
      state_q <= S_IDLE;
      last_q  <= PORT_B;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      busy_q  <= busy;
    end
  end

  // NOTE: both frames are plain flop arrays, not RAM, so they take the reset like any other state.
  always_ff @(posedge sysclock) begin
    if (sysreset) begin
      cipo_q <= '0;
    end else if (alarm_entry) begin
      cipo_q <= '0;
    end else if (gnt_a) begin
      cipo_q[{wr.addr_a, 3'b000} +: 8] <= wr.wdata_a;
    end else if (gnt_b) begin
      cipo_q[{wr.addr_b, 3'b000} +: 8] <= wr.wdata_b;
    end
  end

  always_ff @(posedge sysclock) begin
    if (sysreset) begin
      rx_shadow_q   <= '0;
      frame_count_q <= '0;
      rd_data_q     <= '0;
    end else begin
      if (latch_en) begin
        rx_shadow_q   <= copi_data;
        frame_count_q <= frame_count_q + 16'd1;
      end
      rd_data_q <= rx_shadow_q[{rd_addr, 3'b000} +: 8];
    end
  end

  assign wr.gnt_a     = gnt_a;
  assign wr.gnt_b     = gnt_b;
  assign cipo_data    = cipo_q;
  assign rd_data      = rd_data_q;
  assign frame_count  = frame_count_q;
  assign frame_valid  = (state_q == S_DONE);
  assign alarm_active = (state_q == S_ALARM);

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler: episode-level stimulus feeds a byte-array reference model,
// whose per-cycle expectations are queued and compared by an independent monitor.
module tb_spi_frame_scheduler;

  logic          clk = 1'b0;
  logic          sysreset;
  logic          busy;
  logic          wdog_alarm;
  logic [2047:0] copi_data;
  logic [2047:0] cipo_data;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [15:0]   frame_count;
  logic          alarm_active;

  always #5 clk = ~clk;

  spi_frame_scheduler_if wif ();

  spi_frame_scheduler dut (
    .sysclock     (clk),
    .sysreset     (sysreset),
    .busy         (busy),
    .wdog_alarm   (wdog_alarm),
    .copi_data    (copi_data),
    .cipo_data    (cipo_data),
    .wr           (wif),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_valid  (frame_valid),
    .frame_count  (frame_count),
    .alarm_active (alarm_active)
  );

  typedef struct {
    logic          ga;
    logic          gb;
    logic          fv;
    logic [15:0]   fc;
    logic          al;
    logic [7:0]    rd;
    logic [2047:0] cipo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: frames as byte arrays, requesters as pending flags.
  logic [7:0]  tx_m    [256];
  logic [7:0]  rx_m    [256];
  logic [7:0]  rx_pend [256];
  logic [15:0] fcount_m;
  bit          last_b;
  logic [7:0]  rd_exp;
  bit          pend_a, pend_b;
  logic [7:0]  pa_addr, pa_data, pb_addr, pb_data;
  bit          gen_en;
  int          rd_fix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
    for (int k = 0; k < 256; k++) begin
      if (a[8*k +: 8] !== b[8*k +: 8]) return k;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("gnt_a",        32'(wif.gnt_a),     32'(mon_e.ga));
      check("gnt_b",        32'(wif.gnt_b),     32'(mon_e.gb));
      check("frame_valid",  32'(frame_valid),   32'(mon_e.fv));
      check("frame_count",  32'(frame_count),   32'(mon_e.fc));
      check("alarm_active", 32'(alarm_active),  32'(mon_e.al));
      check("rd_data",      32'(rd_data),       32'(mon_e.rd));
      total++;
      if (cipo_data !== mon_e.cipo) begin
        bad++;
        $display("FAIL cipo_data byte %0d: got 0x%0h, want 0x%0h (t=%0t)",
                 first_diff(cipo_data, mon_e.cipo),
                 cipo_data[8*first_diff(cipo_data, mon_e.cipo) +: 8],
                 mon_e.cipo[8*first_diff(cipo_data, mon_e.cipo) +: 8], $time);
      end
    end
  end

  function automatic logic [2047:0] pack_tx();
    logic [2047:0] v;
    for (int k = 0; k < 256; k++) v[8*k +: 8] = tx_m[k];
    return v;
  endfunction

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_copi(input int fixed_idx, input logic [7:0] fixed_val);
    logic [7:0] b;
    for (int k = 0; k < 256; k++) begin
      b = (k == fixed_idx) ? fixed_val : 8'($urandom);
      copi_data[8*k +: 8] = b;
      rx_pend[k] = b;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 256; k++) begin
      tx_m[k] = 8'h00;
      rx_m[k] = 8'h00;
    end
    fcount_m = 16'h0000;
    last_b   = 1'b1;
    rd_exp   = 8'h00;
  endtask

  // One clock cycle. Flags describe what the schedule implies for this cycle:
  // open_v = writes accepted, fv_v = a frame became visible at the edge starting it,
  // al_v = scheduler alarmed, clr_v = first alarmed cycle, rst_v = reset held.
  task automatic step(input logic b, input logic w, input bit open_v, input bit fv_v,
                      input bit al_v, input bit clr_v, input bit rst_v);
    exp_t r;
    bit   ga, gb;
    @(posedge clk);
    #1;
    if (gen_en) begin
      if (!pend_a && $urandom_range(0, 2) == 0) begin
        pend_a = 1'b1; pa_addr = rand_addr(); pa_data = 8'($urandom);
      end
      if (!pend_b && $urandom_range(0, 2) == 0) begin
        pend_b = 1'b1; pb_addr = rand_addr(); pb_data = 8'($urandom);
      end
    end
    sysreset    = rst_v;
    busy        = b;
    wdog_alarm  = w;
    wif.req_a   = pend_a;
    wif.addr_a  = pa_addr;
    wif.wdata_a = pa_data;
    wif.req_b   = pend_b;
    wif.addr_b  = pb_addr;
    wif.wdata_b = pb_data;
    rd_addr     = (rd_fix >= 0) ? 8'(rd_fix) : 8'($urandom);

    if (clr_v) for (int k = 0; k < 256; k++) tx_m[k] = 8'h00;
    if (fv_v) begin
      for (int k = 0; k < 256; k++) rx_m[k] = rx_pend[k];
      fcount_m = fcount_m + 16'd1;
    end

    ga = 1'b0;
    gb = 1'b0;
    if (open_v && !rst_v) begin
      if (pend_a && pend_b) begin
        ga = last_b;
        gb = !last_b;
      end else begin
        ga = pend_a;
        gb = pend_b;
      end
    end

    r.ga   = ga;
    r.gb   = gb;
    r.fv   = fv_v;
    r.fc   = fcount_m;
    r.al   = al_v;
    r.rd   = rd_exp;
    r.cipo = pack_tx();
    exp_q.push_back(r);

    if (ga) begin tx_m[pa_addr] = pa_data; last_b = 1'b0; pend_a = 1'b0; end
    if (gb) begin tx_m[pb_addr] = pb_data; last_b = 1'b1; pend_b = 1'b0; end
    rd_exp = rx_m[rd_addr];
    if (rst_v) model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // busy high for hi cycles, falls, then LATCH and DONE; chain keeps busy high through both.
  task automatic exchange(input int hi, input bit chain);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(chain, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(chain, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Exchange cut by the watchdog: phase 0 in XFER, 1 in LATCH, 2 in DONE; alarm held k cycles.
  task automatic alarm_exchange(input int hi, input int phase, input int k);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (phase >= 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (phase >= 2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, phase == 2, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < k; j++) step(1'b0, j < k - 1, 1'b0, 1'b0, 1'b1, j == 0, 1'b0);
  endtask

  task automatic reset_mid_exchange(input int hi);
    set_copi(-1, 8'h00);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic reset_mid_alarm(input int hi);
    set_copi(-1, 8'h00);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    sysreset    = 1'b1;
    busy        = 1'b0;
    wdog_alarm  = 1'b0;
    copi_data   = '0;
    rd_addr     = 8'h00;
    wif.req_a   = 1'b0;
    wif.addr_a  = 8'h00;
    wif.wdata_a = 8'h00;
    wif.req_b   = 1'b0;
    wif.addr_b  = 8'h00;
    wif.wdata_b = 8'h00;
    pend_a = 1'b0; pend_b = 1'b0;
    pa_addr = 8'h00; pa_data = 8'h00; pb_addr = 8'h00; pb_data = 8'h00;
    gen_en = 1'b0;
    rd_fix = -1;
    model_reset();
    for (int k = 0; k < 256; k++) rx_pend[k] = 8'h00;
    repeat (2) @(posedge clk);

    // Reset state, with a request already pending that reset must mask.
    pend_a = 1'b1; pa_addr = 8'h00; pa_data = 8'hA5;
    do_reset();
    idle(2);

    // Both requesters held: grants alternate A, B, A, B from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!pend_a) begin pend_a = 1'b1; pa_addr = 8'h10; pa_data = 8'h11; end
      if (!pend_b) begin pend_b = 1'b1; pb_addr = 8'hFF; pb_data = 8'h22; end
      idle(1);
    end
    idle(2);

    // Pending B blocked by busy, LATCH and DONE; granted on the first free IDLE cycle.
    pend_b = 1'b1; pb_addr = 8'h42; pb_data = 8'h3C;
    set_copi(-1, 8'h00);
    exchange(6, 1'b0);
    idle(2);

    // Receive frame with byte 3 = 0x5C; read back through the shadow.
    do_reset();
    rd_fix = 3;
    set_copi(3, 8'h5C);
    exchange(10, 1'b0);
    idle(2);
    rd_fix = -1;

    // Counter wrap: preload 0xFFFF, then one more frame.
    @(negedge clk);
    #1;
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    fcount_m = 16'hFFFF;
    idle(1);
    set_copi(-1, 8'h00);
    exchange(3, 1'b0);
    idle(1);

    // busy re-rises during LATCH: DONE still pulses, then straight back into an exchange.
    set_copi(-1, 8'h00);
    exchange(2, 1'b1);
    set_copi(-1, 8'h00);
    exchange(0, 1'b0);
    idle(1);

    // Watchdog during LATCH with a nonzero frame and A pending.
    pend_a = 1'b1; pa_addr = 8'h07; pa_data = 8'h77;
    idle(1);
    pend_a = 1'b1; pa_addr = 8'h20; pa_data = 8'h99;
    set_copi(-1, 8'h00);
    alarm_exchange(4, 1, 3);
    idle(2);

    reset_mid_alarm(3);
    idle(1);

    // Randomized episodes.
    gen_en = 1'b1;
    for (int e = 0; e < 150; e++) begin
      case ($urandom_range(0, 5))
        0, 1: idle($urandom_range(1, 6));
        2, 3: begin
          set_copi(-1, 8'h00);
          if ($urandom_range(0, 2) == 0) begin
            exchange($urandom_range(1, 12), 1'b1);
            set_copi(-1, 8'h00);
            exchange($urandom_range(0, 8), 1'b0);
          end else begin
            exchange($urandom_range(1, 12), 1'b0);
          end
        end
        4: begin
          set_copi(-1, 8'h00);
          alarm_exchange($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(1, 3));
        end
        default: reset_mid_exchange($urandom_range(1, 5));
      endcase
    end
    gen_en = 1'b0;
    idle(4);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
